// File: rtl/irq_ctrl.sv
// Interrupt front-end: synchronises raw IRQ lines, detects edge/level per source,
// keeps sticky pending bits gated by an enable mask, and exposes PEND/EN/MODE/ID registers.
module irq_ctrl #(
  parameter int unsigned N_SRC       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic [N_SRC-1:0] interrupt,
  output logic             irq_any
);

  localparam int unsigned ID_W = 5;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_EN   = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_en;
  logic [N_SRC-1:0] r_mode;

  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [ID_W-1:0]  w_id;
  logic             w_unused;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s & ~r_prev;
  assign w_w1c    = (we && addr == ADDR_PEND) ? wd[N_SRC-1:0] : '0;
  assign w_unused = ^wd[31:N_SRC];

  // Edge sources are sticky (a new rise beats a same-cycle clear); level sources track s.
  assign w_pend_nxt = (r_mode & ((r_pend & ~w_w1c) | w_rise)) | (~r_mode & w_s);

  // Synchroniser chain plus the one-cycle-delayed copy used for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_prev <= w_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_en   <= '0;
      r_mode <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (we && addr == ADDR_EN)   r_en   <= wd[N_SRC-1:0];
      if (we && addr == ADDR_MODE) r_mode <= wd[N_SRC-1:0];
    end
  end

  assign interrupt = r_pend & r_en;
  assign irq_any   = |interrupt;

  // Lowest active index wins; scanning downward leaves the lowest one last.
  always_comb begin
    w_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (interrupt[i]) w_id = ID_W'(i + 1);
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_PEND: rd = 32'(r_pend);
      ADDR_EN:   rd = 32'(r_en);
      ADDR_MODE: rd = 32'(r_mode);
      ADDR_ID:   rd = 32'(w_id);
      default:   rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a history-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_irq_ctrl;

  localparam int unsigned N    = 6;
  localparam int unsigned SYNC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          we;
  logic [1:0]    addr;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [N-1:0]  interrupt;
  logic          irq_any;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .interrupt(interrupt), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  // Reference model: hist[k] is irq_in as sampled k edges ago.
  logic [N-1:0] hist [SYNC+1];
  logic [N-1:0] m_pend, m_en, m_mode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
      m_pend = '0; m_en = '0; m_mode = '0;
    end else begin
      logic [N-1:0] s_old, p_old, clr;
      s_old = hist[SYNC-1];
      p_old = hist[SYNC];
      clr   = (we && addr == 2'd0) ? wd[N-1:0] : '0;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) m_pend[i] = (s_old[i] && !p_old[i]) ? 1'b1 : (m_pend[i] && !clr[i]);
        else           m_pend[i] = s_old[i];
      end
      if (we && addr == 2'd1) m_en   = wd[N-1:0];
      if (we && addr == 2'd2) m_mode = wd[N-1:0];
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_in;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    logic [N-1:0] act;
    int id;
    act = m_pend & m_en;
    id = 0;
    for (int i = N - 1; i >= 0; i--) if (act[i]) id = i + 1;
    case (a)
      2'd0: return 32'(m_pend);
      2'd1: return 32'(m_en);
      2'd2: return 32'(m_mode);
      default: return 32'(id);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("model_interrupt", 32'(interrupt), 32'(m_pend & m_en));
    chk("model_irq_any", 32'(irq_any), 32'(|(m_pend & m_en)));
    chk("model_rd", rd, model_rd(addr));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1 chk(name, rd, exp);
  endtask

  task automatic edge_chk(input string name, input logic [N-1:0] exp);
    @(posedge clk);
    #1 chk(name, 32'(interrupt), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; we = 1'b0; addr = '0; wd = '0;
    repeat (3) @(posedge clk);
    for (int a = 0; a < 4; a++) rdchk("reset_rd", 2'(a), 32'h0);
    chk("reset_int", 32'(interrupt), 32'h0);
    chk("reset_any", 32'(irq_any), 32'h0);
    @(negedge clk) rst = 1'b0;

    // Edge mode on src 0: 3-edge latency, sticky, W1C.
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h01);
    @(negedge clk) irq_in[0] = 1'b1;
    edge_chk("edge_lat_e1", 6'h00);
    @(negedge clk) irq_in[0] = 1'b0;
    edge_chk("edge_lat_e2", 6'h00);
    edge_chk("edge_lat_e3", 6'h01);
    rdchk("edge_id", 2'd3, 32'd1);
    repeat (3) edge_chk("edge_sticky", 6'h01);
    wr(2'd0, 32'h01);
    chk("edge_w1c", 32'(interrupt), 32'h0);

    // Level mode on src 3.
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h08);
    @(negedge clk) irq_in[3] = 1'b1;
    edge_chk("lvl_e1", 6'h00);
    edge_chk("lvl_e2", 6'h00);
    edge_chk("lvl_e3", 6'h08);
    wr(2'd0, 32'h08);
    rdchk("lvl_w1c_refollow", 2'd0, 32'h08);
    @(negedge clk) irq_in[3] = 1'b0;
    edge_chk("lvl_fall_e1", 6'h08);
    edge_chk("lvl_fall_e2", 6'h08);
    edge_chk("lvl_fall_e3", 6'h00);

    // Masking on src 5.
    wr(2'd1, 32'h00);
    wr(2'd2, 32'h3F);
    @(negedge clk) irq_in[5] = 1'b1;
    @(negedge clk) irq_in[5] = 1'b0;
    repeat (3) @(posedge clk);
    rdchk("mask_pend", 2'd0, 32'h20);
    chk("mask_int", 32'(interrupt), 32'h0);
    rdchk("mask_id", 2'd3, 32'd0);
    wr(2'd1, 32'h20);
    chk("unmask_int", 32'(interrupt), 32'h20);
    rdchk("unmask_id", 2'd3, 32'd6);

    // Priority and set-vs-clear collision.
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    @(negedge clk) irq_in = 6'h14;
    @(negedge clk) irq_in = 6'h00;
    repeat (3) @(posedge clk);
    rdchk("prio_id", 2'd3, 32'd3);
    wr(2'd0, 32'h3F);
    @(negedge clk) irq_in[2] = 1'b1;
    @(negedge clk) irq_in[2] = 1'b0;
    @(negedge clk) begin we = 1'b1; addr = 2'd0; wd = 32'h04; end
    @(posedge clk);
    #1 we = 1'b0;
    chk("collide_set_wins", rd, 32'h04);
    wr(2'd0, 32'h04);
    chk("collide_then_clear", rd, 32'h00);

    // Asynchronous reset mid-cycle with everything pending.
    wr(2'd2, 32'h00);
    @(negedge clk) irq_in = 6'h3F;
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_int", 32'(interrupt), 32'h3F);
    @(posedge clk);
    #3 irq_in = 6'h02; addr = 2'd0; rst = 1'b1;
    #1 chk("async_rst_int", 32'(interrupt), 32'h0);
    chk("async_rst_any", 32'(irq_any), 32'h0);
    chk("async_rst_rd", rd, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wr(2'd2, 32'h02);
    wr(2'd1, 32'h02);
    repeat (3) @(posedge clk);
    #1 chk("post_rst_int", 32'(interrupt), 32'h02);
    rdchk("post_rst_id", 2'd3, 32'd2);
    wr(2'd0, 32'h02);
    repeat (5) edge_chk("post_rst_single", 6'h00);

    @(negedge clk) irq_in = '0;
    repeat (4) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
